video_timing_detect: RTL and testbench

VIDEO_TIMING_DETECT -- requirements
Module: video_timing_detect

---
 rtl/video_timing_detect.sv | 157 +++++++++++++++
 tb/tb_video_timing_detect.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_detect.sv
// Video timing detector: measures line and frame geometry from hsync/vsync/de
// and reports it once enough consecutive frames agree.
module video_timing_detect #(
  parameter int STABLE_FRAMES    = 2,
  parameter int TIMEOUT_BITS     = 24,
  parameter bit SYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic        clock,
  input  logic        rstn,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  output logic [12:0] h_total,
  output logic [12:0] h_active,
  output logic [11:0] v_total,
  output logic [11:0] v_active,
  output logic        locked,
  output logic        frame_start,
  output logic        mode_changed,
  output logic [1:0]  fsm_state
);
  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic SYNC_INV = ~SYNC_ACTIVE_HIGH;

  state_t state, state_n;
  logic hs_r, vs_r, de_r, hs_d, vs_d;
  logic hs_lead, vs_lead;
  logic [12:0] h_cnt, de_cnt, line_len, line_act;
  logic [11:0] v_cnt, va_cnt;
  logic line_de, sat_flag;
  logic [TIMEOUT_BITS-1:0] wd_cnt;
  logic [3:0] match_cnt, match_n;
  logic [12:0] cand_ht, cand_ha;
  logic [11:0] cand_vt, cand_va;
  logic h_sat, de_sat, v_sat, va_sat, new_line_de, timeout;
  logic [12:0] f_ht, f_ha;
  logic [11:0] f_vt, f_va;
  logic f_bad, f_same, cand_load, out_load, mc_n;

  assign hs_lead = hs_r & ~hs_d;
  assign vs_lead = vs_r & ~vs_d;
  assign timeout = &wd_cnt;
  assign fsm_state = state;

  // A line counts toward v_active on its first de cycle.
  assign new_line_de = de_r & (hs_lead | ~line_de);
  assign h_sat  = (h_cnt == '1) & ~hs_lead;
  assign de_sat = (de_cnt == '1) & de_r & ~hs_lead;
  assign v_sat  = (v_cnt == '1) & hs_lead & ~vs_lead;
  assign va_sat = (va_cnt == '1) & new_line_de & ~vs_lead;

  // Frame tuple as seen at a vsync leading edge; a coincident hsync closes the last line.
  assign f_ht   = hs_lead ? h_cnt : line_len;
  assign f_ha   = (hs_lead && de_cnt != '0) ? de_cnt : line_act;
  assign f_vt   = v_cnt;
  assign f_va   = va_cnt;
  assign f_bad  = sat_flag | h_sat | de_sat | v_sat | va_sat;
  assign f_same = (f_ht == cand_ht) && (f_ha == cand_ha) && (f_vt == cand_vt) && (f_va == cand_va);

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      hs_r <= 1'b0; vs_r <= 1'b0; de_r <= 1'b0; hs_d <= 1'b0; vs_d <= 1'b0;
      h_cnt <= '0; de_cnt <= '0; line_len <= '0; line_act <= '0;
      v_cnt <= '0; va_cnt <= '0; line_de <= 1'b0; sat_flag <= 1'b0;
      wd_cnt <= '0;
    end else begin
      hs_r <= hsync ^ SYNC_INV;
      vs_r <= vsync ^ SYNC_INV;
      de_r <= de;
      hs_d <= hs_r;
      vs_d <= vs_r;
      if (hs_lead) begin
        h_cnt    <= 13'd1;
        line_len <= h_cnt;
        de_cnt   <= {12'd0, de_r};
        if (de_cnt != '0) line_act <= de_cnt;
      end else begin
        if (!h_sat) h_cnt <= h_cnt + 1'b1;
        if (de_r && !de_sat) de_cnt <= de_cnt + 1'b1;
      end
      line_de <= hs_lead ? de_r : (line_de | de_r);
      if (vs_lead) begin
        v_cnt    <= {11'd0, hs_lead};
        va_cnt   <= {11'd0, new_line_de};
        sat_flag <= 1'b0;
      end else begin
        if (hs_lead && !v_sat) v_cnt <= v_cnt + 1'b1;
        if (new_line_de && !va_sat) va_cnt <= va_cnt + 1'b1;
        sat_flag <= f_bad;
      end
      wd_cnt <= (vs_lead || timeout) ? '0 : wd_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    match_n   = match_cnt;
    cand_load = 1'b0;
    out_load  = 1'b0;
    mc_n      = 1'b0;
    if (vs_lead) begin
      case (state)
        SEARCH: begin
          state_n   = MEASURE;
          match_n   = 4'd0;
          cand_load = 1'b1;
        end
        MEASURE: begin
          cand_load = 1'b1;
          if (f_bad)                        match_n = 4'd0;
          else if (f_same && match_cnt != '1) match_n = match_cnt + 4'd1;
          else if (!f_same)                 match_n = 4'd1;
          if (!f_bad && int'(match_n) >= STABLE_FRAMES) begin
            state_n  = LOCKED;
            out_load = 1'b1;
          end
        end
        LOCKED: begin
          if (f_bad || !f_same) begin
            state_n   = MEASURE;
            mc_n      = 1'b1;
            match_n   = f_bad ? 4'd0 : 4'd1;
            cand_load = 1'b1;
          end
        end
        default: state_n = SEARCH;
      endcase
    end else if (timeout) begin
      state_n = SEARCH;
      match_n = 4'd0;
      mc_n    = (state == LOCKED);
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state <= SEARCH;
      match_cnt <= '0;
      cand_ht <= '0; cand_ha <= '0; cand_vt <= '0; cand_va <= '0;
      h_total <= '0; h_active <= '0; v_total <= '0; v_active <= '0;
      locked <= 1'b0; frame_start <= 1'b0; mode_changed <= 1'b0;
    end else begin
      state     <= state_n;
      match_cnt <= match_n;
      if (cand_load) begin
        cand_ht <= f_ht; cand_ha <= f_ha; cand_vt <= f_vt; cand_va <= f_va;
      end
      if (out_load) begin
        h_total <= f_ht; h_active <= f_ha; v_total <= f_vt; v_active <= f_va;
      end
      locked       <= (state_n == LOCKED);
      frame_start  <= vs_lead;
      mode_changed <= mc_n;
    end
  end
endmodule

// File: tb/tb_video_timing_detect.sv
// Bench for video_timing_detect: three instances (active-high with short
// watchdog, active-low, active-high with default watchdog) share one stimulus.
module tb_video_timing_detect;
  logic clock = 1'b0;
  logic rstn, hsync, vsync, de;
  logic [12:0] ht [3];
  logic [12:0] ha [3];
  logic [11:0] vt [3];
  logic [11:0] va [3];
  logic lk [3];
  logic fs [3];
  logic mc [3];
  logic [1:0] st [3];

  int total = 0;
  int bad = 0;
  int mc_cnt [3] = '{0, 0, 0};
  logic [49:0] exp_q [$];

  logic s_lk [3];
  logic s_fs [3];
  logic s_mc [3];
  logic [12:0] s_ht [3];
  logic [12:0] s_ha [3];
  logic [11:0] s_vt [3];
  logic [11:0] s_va [3];
  logic s_fs1, s_fs3, s_mc3;

  video_timing_detect #(.STABLE_FRAMES(2), .TIMEOUT_BITS(8), .SYNC_ACTIVE_HIGH(1'b1)) dut_a (
    .clock(clock), .rstn(rstn), .hsync(hsync), .vsync(vsync), .de(de),
    .h_total(ht[0]), .h_active(ha[0]), .v_total(vt[0]), .v_active(va[0]),
    .locked(lk[0]), .frame_start(fs[0]), .mode_changed(mc[0]), .fsm_state(st[0]));

  video_timing_detect #(.STABLE_FRAMES(2), .TIMEOUT_BITS(8), .SYNC_ACTIVE_HIGH(1'b0)) dut_b (
    .clock(clock), .rstn(rstn), .hsync(~hsync), .vsync(~vsync), .de(de),
    .h_total(ht[1]), .h_active(ha[1]), .v_total(vt[1]), .v_active(va[1]),
    .locked(lk[1]), .frame_start(fs[1]), .mode_changed(mc[1]), .fsm_state(st[1]));

  video_timing_detect #(.STABLE_FRAMES(2), .TIMEOUT_BITS(24), .SYNC_ACTIVE_HIGH(1'b1)) dut_c (
    .clock(clock), .rstn(rstn), .hsync(hsync), .vsync(vsync), .de(de),
    .h_total(ht[2]), .h_active(ha[2]), .v_total(vt[2]), .v_active(va[2]),
    .locked(lk[2]), .frame_start(fs[2]), .mode_changed(mc[2]), .fsm_state(st[2]));

  // clock / reset
  always #5 clock = ~clock;

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) if (mc[i] === 1'b1) mc_cnt[i]++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_tuple(input string tag, input logic [49:0] got,
                             input int eht, input int eha, input int evt, input int eva);
    exp_q.push_back({13'(eht), 13'(eha), 12'(evt), 12'(eva)});
    check(tag, {14'd0, got}, {14'd0, exp_q.pop_front()});
  endtask

  // driver
  task automatic drive(input logic h, input logic v, input logic d);
    @(posedge clock);
    #1;
    hsync = h;
    vsync = v;
    de    = d;
  endtask

  task automatic take_snap();
    for (int i = 0; i < 3; i++) begin
      s_lk[i] = lk[i]; s_fs[i] = fs[i]; s_mc[i] = mc[i];
      s_ht[i] = ht[i]; s_ha[i] = ha[i]; s_vt[i] = vt[i]; s_va[i] = va[i];
    end
  endtask

  // Lines start with a 2-cycle hsync; vsync covers lines 0-1; de spans
  // lines 2..2+v_act-1, pixels 4..4+h_act-1. ext_line gets 9000 extra hsync-free cycles.
  task automatic send_frame(input int h_tot, input int h_act, input int lines, input int v_act,
                            input bit vs_on, input int ext_line);
    for (int ln = 0; ln < lines; ln++) begin
      for (int x = 0; x < h_tot; x++) begin
        drive(x < 2, vs_on && ln < 2,
              (ln >= 2) && (ln < 2 + v_act) && (x >= 4) && (x < 4 + h_act));
        if (vs_on && ln == 0) begin
          if (x == 1) s_fs1 = fs[0];
          if (x == 2) take_snap();
          if (x == 3) begin s_fs3 = fs[0]; s_mc3 = mc[0]; end
        end
        if (ln == ext_line && x == h_tot - 1) repeat (9000) drive(1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  function automatic logic [49:0] tup(input int i);
    return {s_ht[i], s_ha[i], s_vt[i], s_va[i]};
  endfunction

  initial begin
    hsync = 1'b0; vsync = 1'b0; de = 1'b0; rstn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_locked", {63'd0, lk[0]}, 64'd0);
    check("rst_fs", {63'd0, fs[0]}, 64'd0);
    check("rst_mc", {63'd0, mc[0]}, 64'd0);
    check("rst_state", {62'd0, st[0]}, 64'd0);
    check_tuple("rst_tuple", {ht[0], ha[0], vt[0], va[0]}, 0, 0, 0, 0);
    rstn = 1'b1;
    repeat (5) drive(1'b0, 1'b0, 1'b0);

    // lock at 3rd vsync leading edge
    send_frame(20, 12, 10, 6, 1'b1, -1);
    check("f1_fs", {63'd0, s_fs[0]}, 64'd1);
    check("fs_latency", {63'd0, s_fs1}, 64'd0);
    check("f1_locked", {63'd0, s_lk[0]}, 64'd0);
    send_frame(20, 12, 10, 6, 1'b1, -1);
    check("f2_locked", {63'd0, s_lk[0]}, 64'd0);
    check("fs_width", {63'd0, s_fs3}, 64'd0);
    send_frame(20, 12, 10, 6, 1'b1, -1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("f3_locked_%0d", i), {63'd0, s_lk[i]}, 64'd1);
      check_tuple($sformatf("f3_tuple_%0d", i), tup(i), 20, 12, 10, 6);
    end
    send_frame(20, 12, 10, 6, 1'b1, -1);
    check("f4_locked", {63'd0, s_lk[0]}, 64'd1);
    check("f4_no_mc", 64'(mc_cnt[0]), 64'd0);

    // mode change to 24/16
    send_frame(24, 16, 10, 6, 1'b1, -1);
    check("g1_still_locked", {63'd0, s_lk[0]}, 64'd1);
    check("g1_no_mc", {63'd0, s_mc[0]}, 64'd0);
    send_frame(24, 16, 10, 6, 1'b1, -1);
    check("g2_mc", {63'd0, s_mc[0]}, 64'd1);
    check("g2_fs", {63'd0, s_fs[0]}, 64'd1);
    check("g2_unlocked", {63'd0, s_lk[0]}, 64'd0);
    check("g2_mc_width", {63'd0, s_mc3}, 64'd0);
    check_tuple("g2_hold", tup(0), 20, 12, 10, 6);
    send_frame(24, 16, 10, 6, 1'b1, -1);
    check("g3_relock", {63'd0, s_lk[0]}, 64'd1);
    check_tuple("g3_tuple", tup(0), 24, 16, 10, 6);
    check("g3_mc_total", 64'(mc_cnt[0]), 64'd1);

    // watchdog timeout: 480 cycles without vsync
    send_frame(24, 16, 20, 0, 1'b0, -1);
    check("to_unlocked", {63'd0, lk[0]}, 64'd0);
    check("to_unlocked_b", {63'd0, lk[1]}, 64'd0);
    check("to_mc_total", 64'(mc_cnt[0]), 64'd2);
    check("to_state", {62'd0, st[0]}, 64'd0);
    check_tuple("to_hold", {ht[0], ha[0], vt[0], va[0]}, 24, 16, 10, 6);
    check("to_long_wd_locked", {63'd0, lk[2]}, 64'd1);

    send_frame(24, 16, 10, 6, 1'b1, -1);
    check("t0_c_unlocked", {63'd0, s_lk[2]}, 64'd0);
    check("t0_c_mc", {63'd0, s_mc[2]}, 64'd1);
    send_frame(24, 16, 10, 6, 1'b1, -1);
    check("t1_a_unlocked", {63'd0, s_lk[0]}, 64'd0);
    send_frame(24, 16, 10, 6, 1'b1, -1);
    check("t2_a_relock", {63'd0, s_lk[0]}, 64'd1);
    check_tuple("t2_a_tuple", tup(0), 24, 16, 10, 6);
    check("t2_c_relock", {63'd0, s_lk[2]}, 64'd1);

    // saturated frame with an otherwise identical tuple
    send_frame(24, 16, 10, 6, 1'b1, 8);
    check("t3_c_locked", {63'd0, s_lk[2]}, 64'd1);
    send_frame(24, 16, 10, 6, 1'b1, -1);
    check("sat_unlocked", {63'd0, s_lk[2]}, 64'd0);
    check("sat_mc", {63'd0, s_mc[2]}, 64'd1);
    send_frame(24, 16, 10, 6, 1'b1, -1);
    check("sat_clean1_unlocked", {63'd0, s_lk[2]}, 64'd0);
    send_frame(24, 16, 10, 6, 1'b1, -1);
    check("sat_clean2_locked", {63'd0, s_lk[2]}, 64'd1);
    check_tuple("sat_tuple", tup(2), 24, 16, 10, 6);

    // reset mid-frame
    send_frame(20, 12, 5, 6, 1'b1, -1);
    rstn = 1'b0;
    #1;
    check("mid_rst_locked", {63'd0, lk[2]}, 64'd0);
    check_tuple("mid_rst_tuple", {ht[2], ha[2], vt[2], va[2]}, 0, 0, 0, 0);
    check("mid_rst_state", {62'd0, st[2]}, 64'd0);
    repeat (2) @(posedge clock);
    #1;
    rstn = 1'b1;
    send_frame(20, 12, 10, 6, 1'b1, -1);
    check("u1_unlocked", {63'd0, s_lk[2]}, 64'd0);
    send_frame(20, 12, 10, 6, 1'b1, -1);
    check("u2_unlocked", {63'd0, s_lk[2]}, 64'd0);
    send_frame(20, 12, 10, 6, 1'b1, -1);
    check("u3_locked", {63'd0, s_lk[2]}, 64'd1);
    check_tuple("u3_tuple", tup(2), 20, 12, 10, 6);
    check_tuple("u3_tuple_pol", tup(1), 20, 12, 10, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
